// File: rtl/pc_image_receiver_pkg.sv
// Shared types and protocol constants for the PC image receiver.
package pc_image_receiver_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA_HI,
        DATA_LO,
        CHECKSUM,
        ACK
    } rx_state_t;

    localparam logic [7:0] SOF0     = 8'hAA;
    localparam logic [7:0] SOF1     = 8'h55;
    localparam logic [7:0] ACK_BYTE = 8'h06;
    localparam logic [7:0] NAK_BYTE = 8'h15;

endpackage

// File: rtl/pc_image_receiver_if.sv
// Byte stream in, frame-buffer write port and ACK/NAK response out.
interface pc_image_receiver_if #(
    parameter int ADDR_WIDTH = 16
);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  fb_we;
    logic [ADDR_WIDTH-1:0] fb_wAddr;
    logic [15:0]           fb_wData;
    logic                  ack_valid;
    logic [7:0]            ack_data;
    logic                  ack_ready;
    logic                  busy;
    logic                  img_valid;
    logic                  frame_done;
    logic                  frame_err;

    // Byte source / response sink side
    modport master (
        output rx_data, rx_valid, ack_ready,
        input  fb_we, fb_wAddr, fb_wData, ack_valid, ack_data,
               busy, img_valid, frame_done, frame_err
    );

    // Receiver side
    modport slave (
        input  rx_data, rx_valid, ack_ready,
        output fb_we, fb_wAddr, fb_wData, ack_valid, ack_data,
               busy, img_valid, frame_done, frame_err
    );
endinterface

// File: rtl/pc_image_receiver_rx_timeout_counter.sv
// Idle-cycle watchdog: counts enabled cycles since the last clear and flags
// the cycle on which the limit is reached.
module rx_timeout_counter #(
    parameter int CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [CW-1:0] r_cnt;

    // Expiry fires on the CYCLES-th consecutive enabled, uncleared cycle
    assign o_expired = i_enable && !i_clear && (r_cnt == CW'(CYCLES - 1));

    // Count idle cycles; saturate at the limit, restart on clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_cnt <= '0;
        else if (i_clear)
            r_cnt <= '0;
        else if (i_enable && !o_expired)
            r_cnt <= r_cnt + 1'b1;
    end
endmodule

// File: rtl/pc_image_receiver.sv
// Framed RGB565 receiver: AA 55 header, 2N pixel bytes (high first), XOR
// checksum. Writes pixels to the frame buffer and answers with ACK/NAK.
module pc_image_receiver
    import pc_image_receiver_pkg::*;
#(
    parameter int IMG_WIDTH      = 176,
    parameter int IMG_HEIGHT     = 240,
    parameter int ADDR_WIDTH     = $clog2(IMG_WIDTH * IMG_HEIGHT),
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                 clk,
    input  logic                 reset,
    pc_image_receiver_if.slave   bus
);
    localparam int                    N         = IMG_WIDTH * IMG_HEIGHT;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N - 1);

    rx_state_t             r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
    logic [7:0]            r_hi, w_hi_nxt;
    logic [7:0]            r_csum, w_csum_nxt;
    logic                  r_we, w_we_nxt;
    logic [ADDR_WIDTH-1:0] r_wAddr, w_wAddr_nxt;
    logic [15:0]           r_wData, w_wData_nxt;
    logic                  r_ack_valid, w_ack_valid_nxt;
    logic [7:0]            r_ack_data, w_ack_data_nxt;
    logic                  r_img_valid, w_img_valid_nxt;
    logic                  r_done, w_done_nxt;
    logic                  r_err, w_err_nxt;
    logic                  w_timed;
    logic                  w_expired;

    // Only the payload and checksum phases are guarded; a stuck header is harmless
    assign w_timed = (r_state == DATA_HI) || (r_state == DATA_LO) || (r_state == CHECKSUM);

    rx_timeout_counter #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (bus.rx_valid || !w_timed),
        .i_enable  (w_timed),
        .o_expired (w_expired)
    );

    // Next-state and datapath updates for the frame parser
    always_comb begin
        w_state_nxt     = r_state;
        w_addr_nxt      = r_addr;
        w_hi_nxt        = r_hi;
        w_csum_nxt      = r_csum;
        w_we_nxt        = 1'b0;
        w_wAddr_nxt     = r_wAddr;
        w_wData_nxt     = r_wData;
        w_ack_valid_nxt = r_ack_valid;
        w_ack_data_nxt  = r_ack_data;
        w_img_valid_nxt = r_img_valid;
        w_done_nxt      = 1'b0;
        w_err_nxt       = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.rx_valid && bus.rx_data == SOF0)
                    w_state_nxt = SYNC;
            end
            SYNC: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data == SOF1) begin
                        w_state_nxt     = DATA_HI;
                        w_img_valid_nxt = 1'b0;
                        w_addr_nxt      = '0;
                        w_csum_nxt      = '0;
                    end else if (bus.rx_data != SOF0) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            DATA_HI: begin
                if (bus.rx_valid) begin
                    w_hi_nxt    = bus.rx_data;
                    w_csum_nxt  = r_csum ^ bus.rx_data;
                    w_state_nxt = DATA_LO;
                end
            end
            DATA_LO: begin
                if (bus.rx_valid) begin
                    w_csum_nxt  = r_csum ^ bus.rx_data;
                    w_we_nxt    = 1'b1;
                    w_wAddr_nxt = r_addr;
                    w_wData_nxt = {r_hi, bus.rx_data};
                    if (r_addr == LAST_ADDR) begin
                        w_state_nxt = CHECKSUM;
                    end else begin
                        w_addr_nxt  = r_addr + 1'b1;
                        w_state_nxt = DATA_HI;
                    end
                end
            end
            CHECKSUM: begin
                if (bus.rx_valid) begin
                    w_state_nxt     = ACK;
                    w_ack_valid_nxt = 1'b1;
                    if (bus.rx_data == r_csum) begin
                        w_img_valid_nxt = 1'b1;
                        w_done_nxt      = 1'b1;
                        w_ack_data_nxt  = ACK_BYTE;
                    end else begin
                        w_err_nxt      = 1'b1;
                        w_ack_data_nxt = NAK_BYTE;
                    end
                end
            end
            ACK: begin
                // Incoming bytes are ignored until the response is taken
                if (bus.ack_ready) begin
                    w_ack_valid_nxt = 1'b0;
                    w_state_nxt     = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // Expiry only asserts in a guarded state with no byte this cycle
        if (w_expired) begin
            w_state_nxt     = ACK;
            w_err_nxt       = 1'b1;
            w_ack_valid_nxt = 1'b1;
            w_ack_data_nxt  = NAK_BYTE;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_hi        <= '0;
            r_csum      <= '0;
            r_we        <= 1'b0;
            r_wAddr     <= '0;
            r_wData     <= '0;
            r_ack_valid <= 1'b0;
            r_ack_data  <= '0;
            r_img_valid <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_addr      <= w_addr_nxt;
            r_hi        <= w_hi_nxt;
            r_csum      <= w_csum_nxt;
            r_we        <= w_we_nxt;
            r_wAddr     <= w_wAddr_nxt;
            r_wData     <= w_wData_nxt;
            r_ack_valid <= w_ack_valid_nxt;
            r_ack_data  <= w_ack_data_nxt;
            r_img_valid <= w_img_valid_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
        end
    end

    assign bus.fb_we      = r_we;
    assign bus.fb_wAddr   = r_wAddr;
    assign bus.fb_wData   = r_wData;
    assign bus.ack_valid  = r_ack_valid;
    assign bus.ack_data   = r_ack_data;
    assign bus.img_valid  = r_img_valid;
    assign bus.frame_done = r_done;
    assign bus.frame_err  = r_err;
    assign bus.busy       = (r_state != IDLE);

endmodule

// File: tb/tb_pc_image_receiver.sv
// Directed bench for pc_image_receiver with a small 4x2 image.
module tb_pc_image_receiver;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int N  = W * H;
    localparam int AW = 3;
    localparam int TO = 100;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    pc_image_receiver_if #(.ADDR_WIDTH(AW)) bus();

    pc_image_receiver #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // One row = inputs for one cycle and outputs expected just after that edge
    typedef struct {
        logic          v;
        logic [7:0]    d;
        logic          rdy;
        logic          we;
        logic [AW-1:0] addr;
        logic [15:0]   wdata;
        logic          busy;
        logic          img;
        logic          done;
        logic          err;
        logic          ackv;
        logic [7:0]    ackd;
    } vec_t;

    vec_t vq[$];
    int   checks   = 0;
    int   failures = 0;

    // Expected held values, advanced as rows are written
    logic [AW-1:0] e_addr;
    logic [15:0]   e_data;
    logic          e_img;
    logic [7:0]    e_ackd;

    logic [N-1:0][15:0] px_good;
    logic [N-1:0][15:0] px_inc;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic add_row(input logic v, input logic [7:0] d, input logic we, input logic busy,
                           input logic done, input logic err, input logic ackv);
        vec_t r;
        r.v = v; r.d = d; r.rdy = 1'b1; r.we = we; r.addr = e_addr; r.wdata = e_data;
        r.busy = busy; r.img = e_img; r.done = done; r.err = err; r.ackv = ackv; r.ackd = e_ackd;
        vq.push_back(r);
    endtask

    task automatic push_frame(input logic [N-1:0][15:0] pix, input logic [7:0] cs, input bit good);
        add_row(1'b1, 8'hAA, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        e_img = 1'b0;
        add_row(1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < N; i++) begin
            add_row(1'b1, pix[i][15:8], 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            e_addr = AW'(i);
            e_data = pix[i];
            add_row(1'b1, pix[i][7:0], 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        if (good) begin
            e_img  = 1'b1;
            e_ackd = 8'h06;
            add_row(1'b1, cs, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        end else begin
            e_ackd = 8'h15;
            add_row(1'b1, cs, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        end
        // ack taken with ack_ready=1 -> back to IDLE
        add_row(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic run_table(input string tag);
        foreach (vq[i]) begin
            logic ok;
            bus.rx_valid  = vq[i].v;
            bus.rx_data   = vq[i].d;
            bus.ack_ready = vq[i].rdy;
            @(posedge clk); #1;
            ok = (bus.fb_we === vq[i].we) && (bus.fb_wAddr === vq[i].addr) &&
                 (bus.fb_wData === vq[i].wdata) && (bus.busy === vq[i].busy) &&
                 (bus.img_valid === vq[i].img) && (bus.frame_done === vq[i].done) &&
                 (bus.frame_err === vq[i].err) && (bus.ack_valid === vq[i].ackv) &&
                 (!vq[i].ackv || bus.ack_data === vq[i].ackd);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL %s row%0d: got we=%b a=%0d d=%h busy=%b img=%b done=%b err=%b ackv=%b ackd=%h; expected we=%b a=%0d d=%h busy=%b img=%b done=%b err=%b ackv=%b ackd=%h",
                         tag, i, bus.fb_we, bus.fb_wAddr, bus.fb_wData, bus.busy, bus.img_valid,
                         bus.frame_done, bus.frame_err, bus.ack_valid, bus.ack_data,
                         vq[i].we, vq[i].addr, vq[i].wdata, vq[i].busy, vq[i].img,
                         vq[i].done, vq[i].err, vq[i].ackv, vq[i].ackd);
            end
        end
        bus.rx_valid = 1'b0;
        vq.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rx_valid  = 1'b0;
        bus.rx_data   = 8'h00;
        bus.ack_ready = 1'b0;

        px_good[0] = 16'h1234;
        px_good[1] = 16'h5678;
        for (int i = 2; i < N; i++) px_good[i] = 16'hFFFF;
        for (int i = 0; i < N; i++) px_inc[i] = {8'(2 * i + 1), 8'(2 * i + 2)};

        // Reset state
        #12;
        chk("rst_outs", 64'({bus.fb_we, bus.fb_wAddr, bus.fb_wData, bus.ack_valid, bus.ack_data,
                             bus.busy, bus.img_valid, bus.frame_done, bus.frame_err}), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        // Good frame, bad checksum, sync hunting, aborted header
        e_addr = '0; e_data = '0; e_img = 1'b0; e_ackd = 8'h00;
        push_frame(px_good, 8'h08, 1'b1);
        push_frame(px_good, 8'h09, 1'b0);
        add_row(1'b1, 8'h13, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add_row(1'b1, 8'hAA, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        push_frame(px_inc, 8'h10, 1'b1);
        add_row(1'b1, 8'hAA, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        add_row(1'b1, 8'h12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add_row(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_table("tbl");

        // Timeout after header + 3 bytes, ack held off
        bus.ack_ready = 1'b0;
        send_byte(8'hAA);
        send_byte(8'h55);
        send_byte(8'h11);
        send_byte(8'h22);
        chk("to_write", 64'({bus.fb_we, bus.fb_wAddr, bus.fb_wData}), 64'({1'b1, 3'd0, 16'h1122}));
        chk("to_img_cleared", 64'(bus.img_valid), 64'd0);
        send_byte(8'h33);
        begin
            logic early = 1'b0;
            for (int k = 1; k < TO; k++) begin
                @(posedge clk); #1;
                if (bus.frame_err || bus.ack_valid || !bus.busy) early = 1'b1;
            end
            chk("to_no_early", 64'(early), 64'd0);
        end
        @(posedge clk); #1;
        chk("to_err", 64'(bus.frame_err), 64'd1);
        chk("to_ack", 64'({bus.ack_valid, bus.ack_data}), 64'({1'b1, 8'h15}));
        chk("to_busy_img", 64'({bus.busy, bus.img_valid}), 64'({1'b1, 1'b0}));

        // Backpressure: bytes arriving during ACK must be dropped
        begin
            logic [7:0] seq [4];
            logic bad = 1'b0;
            seq[0] = 8'hAA; seq[1] = 8'h55; seq[2] = 8'h12; seq[3] = 8'h34;
            for (int k = 0; k < 20; k++) begin
                bus.rx_valid = 1'b1;
                bus.rx_data  = seq[k % 4];
                @(posedge clk); #1;
                if (!bus.ack_valid || bus.ack_data !== 8'h15 || bus.fb_we || bus.frame_err ||
                    bus.frame_done || !bus.busy) bad = 1'b1;
            end
            bus.rx_valid = 1'b0;
            chk("bp_stable", 64'(bad), 64'd0);
        end
        bus.ack_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release", 64'({bus.busy, bus.ack_valid}), 64'd0);
        @(posedge clk); #1;
        chk("bp_idle", 64'({bus.busy, bus.fb_we}), 64'd0);

        // Reset mid-frame after 5 pixels
        send_byte(8'hAA);
        send_byte(8'h55);
        for (int i = 0; i < 5; i++) begin
            send_byte(8'hA0 + 8'(i));
            send_byte(8'h0B);
        end
        chk("mid_write", 64'({bus.fb_we, bus.fb_wAddr, bus.fb_wData}), 64'({1'b1, 3'd4, 16'hA40B}));
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_outs", 64'({bus.fb_we, bus.fb_wAddr, bus.fb_wData, bus.ack_valid, bus.ack_data,
                                 bus.busy, bus.img_valid, bus.frame_done, bus.frame_err}), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("mid_no_ack", 64'({bus.ack_valid, bus.frame_err}), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        // Clean frame afterwards starts at address 0
        e_addr = '0; e_data = '0; e_img = 1'b0; e_ackd = 8'h00;
        push_frame(px_good, 8'h08, 1'b1);
        run_table("post");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pc_image_receiver.md
Name: pc_image_receiver

Overview:
- Upstream stage of the PC image frame buffer: parses a framed RGB565 image arriving byte-wise from the UART RX and drives the buffer's write port (we/wAddr/wData) on the system clock.
- Validates each frame with an XOR checksum, times out stalled transfers, and returns a one-byte ACK/NAK to the UART TX.
- Asserts img_valid only after a complete, checksum-correct frame, so the edge controller never consumes a partial image.

Parameters:
- IMG_WIDTH, 176, pixels per line
- IMG_HEIGHT, 240, lines per frame
- ADDR_WIDTH, $clog2(IMG_WIDTH*IMG_HEIGHT), frame buffer address width
- TIMEOUT_CYCLES, 1_000_000, maximum idle clk cycles between bytes inside a frame (10 ms at 100 MHz)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- rx_data  in  8  received UART byte
- rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle
- fb_we  out  1  frame buffer write enable, one-cycle pulse
- fb_wAddr  out  ADDR_WIDTH  pixel address, 0..IMG_WIDTH*IMG_HEIGHT-1
- fb_wData  out  16  RGB565 pixel
- ack_valid  out  1  response byte available for UART TX
- ack_data  out  8  0x06 = ACK, 0x15 = NAK
- ack_ready  in  1  TX accepts ack_data when ack_valid && ack_ready
- busy  out  1  high in any state other than IDLE
- img_valid  out  1  level: the buffer holds a complete, good frame
- frame_done  out  1  one-cycle pulse on good checksum
- frame_err  out  1  one-cycle pulse on bad checksum or timeout

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, all outputs 0, address counter 0, checksum 0, timeout counter 0.
- Frame format: 0xAA, 0x55, then N=IMG_WIDTH*IMG_HEIGHT pixels sent high byte first (2N bytes), then 1 checksum byte equal to the XOR of all 2N pixel bytes.
- IDLE: rx 0xAA -> SYNC; any other byte is ignored.
- SYNC: 0x55 -> DATA_HI, and on that transition clear img_valid, address counter and checksum; 0xAA -> remain in SYNC; any other byte -> IDLE.
- DATA_HI: latch the byte as the high half -> DATA_LO.
- DATA_LO: on the cycle after rx_valid, fb_we=1 for exactly 1 cycle with fb_wData={hi,lo} and fb_wAddr=current address. Write latency is 1 cycle from the low byte's rx_valid.
  - If address == N-1 -> CHECKSUM; otherwise increment address -> DATA_HI.
  - The address never wraps within a frame.
- Checksum: XOR-accumulate every pixel byte in the cycle it is received (8-bit).
- CHECKSUM: on rx_valid compare the byte against the accumulated XOR.
  - Match -> img_valid=1, frame_done pulse, ack_data=0x06.
  - Mismatch -> img_valid stays 0, frame_err pulse, ack_data=0x15.
  - Either case -> ACK.
- Timeout: in DATA_HI, DATA_LO or CHECKSUM, the timeout counter increments every cycle without rx_valid and resets to 0 on rx_valid. Reaching TIMEOUT_CYCLES -> frame_err pulse, ack_data=0x15, -> ACK. SYNC has no timeout.
- ACK: ack_valid=1 with ack_data held stable until ack_ready=1; on that cycle ack_valid drops and state -> IDLE. rx_valid in ACK is dropped and does not advance parsing.
- img_valid is cleared only by the next 0xAA 0x55 header or by reset. An aborted or bad frame leaves img_valid=0. The buffer contents after an aborted frame are undefined.
- fb_wAddr and fb_wData hold their last values while fb_we=0.
- busy = (state != IDLE).
- Reset asserted mid-frame aborts immediately and no ACK is sent.

Decomposition:
- Shared package holds:
  - enum rx_state_t {IDLE, SYNC, DATA_HI, DATA_LO, CHECKSUM, ACK}
  - constants SOF0=8'hAA, SOF1=8'h55, ACK_BYTE=8'h06, NAK_BYTE=8'h15
- The timeout counter is a natural sub-module, rx_timeout_counter (inputs clear/enable, output expired), reusable by other UART protocol blocks.
- Everything else is one FSM with datapath registers.

Test Plan:
(Bench parameters: IMG_WIDTH=4, IMG_HEIGHT=2, N=8, TIMEOUT_CYCLES=100.)
- Good frame: AA 55, pixels 0x1234, 0x5678, then 6×0xFFFF, checksum 0x08 (XOR of all 16 bytes) -> 8 fb_we pulses at addresses 0..7, first data 0x1234, each 1 cycle after its low byte; frame_done; img_valid=1; ack 0x06.
- Bad checksum: same frame with checksum 0x09 -> 8 writes, frame_err, img_valid=0, ack 0x15.
- Sync hunting: 0x13, AA, AA, 55, then a good frame -> bytes 0x13 and the first AA ignored, frame accepted; header 0xAA 0x12 -> return to IDLE with no writes.
- Timeout: header + 3 bytes, then 100 cycles without rx_valid -> frame_err exactly at cycle 100, ack 0x15, busy drops after the ack handshake.
- ACK backpressure: hold ack_ready=0 for 20 cycles while sending bytes -> ack_valid/ack_data stable, bytes dropped, no writes; ack_ready=1 -> IDLE next cycle.
- Reset mid-frame: reset=0 after 5 pixels -> all outputs 0 asynchronously, no ack; a subsequent good frame is received correctly starting at address 0.
